io_bridge: RTL and testbench
============================

Name: io_bridge

Overview:
Board-side counterpart to the CPU top's I/O pins. It debounces a raw pushbutton into a single-cycle trigger pulse that drives the CPU trigger input. It also watches the CPU's 8-bit data_out bus and queues every changed value in a small FIFO. Queued values are streamed to a host as 8N1 UART frames, closing the loop between the light-sequence program and the outside world.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before the button level is accepted (>=2)
CLKS_PER_BIT, 8, clock cycles per UART bit (>=2)
FIFO_DEPTH, 4, capture FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
btn_in  input  1  raw asynchronous pushbutton level
trigger  output  1  one-cycle pulse to CPU trigger input
data_out  input  8  CPU light/output bus, synchronous to clk
tx  output  1  UART serial out, idle high
busy  output  1  UART frame in progress
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries queued
overflow  output  1  sticky: a changed value was dropped

Behaviour:
- Reset (rst=0, async): trigger=0, tx=1, busy=0, fifo_count=0, overflow=0; synchronizer, debounce state/counter=0, last_val=8'h00, FIFO pointers=0, TX FSM=IDLE. Reset mid-frame aborts the frame; tx goes high immediately.
- Button path: 2-flop synchronizer btn_in -> s1 -> s2.
  - cnt increments each cycle while s2 != btn_state.
  - cnt clears whenever s2 == btn_state.
  - When cnt == DEBOUNCE_CYCLES-1 and s2 != btn_state: btn_state <= s2 and cnt <= 0.
  - trigger is registered and high for exactly one cycle at the edge where btn_state goes 0->1.
  - Timing: btn_in held high, first sampled at edge 1 -> trigger high after edge DEBOUNCE_CYCLES+2 for one cycle.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no pulse.
  - Release is debounced the same way but never pulses.
  - Holding the button produces exactly one pulse.
- Capture path: last_val <= data_out every cycle.
  - push = (data_out != last_val).
  - A push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - If a push is rejected: value dropped, overflow <= 1, held until reset.
  - last_val updates whether or not the push is accepted.
  - An initial data_out of 8'h00 is not queued.
- FIFO: circular, wrap-around pointers; fifo_count updates the cycle after push/pop.
  - Simultaneous push and pop leave count unchanged.
  - A push into an empty FIFO is visible to the TX FSM the next cycle.
- TX FSM states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1, busy=0. If fifo_count != 0: pop the head into shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx = shift[0], LSB first, CLKS_PER_BIT cycles per bit, 8 bits.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy=1 in START/DATA/STOP.
  - Frame length is 10*CLKS_PER_BIT cycles, with at least one IDLE cycle between back-to-back frames.
- Capture and TX run independently; trigger generation never stalls on UART activity.

Test Plan:
- Reset: hold rst=0 with data_out=8'hFF, btn_in=1 -> trigger=0, tx=1, busy=0, fifo_count=0, overflow=0 throughout; release rst -> nothing happens until the debounce/capture logic acts on the new samples.
- Debounce (DEBOUNCE_CYCLES=4): btn_in high from edge 1 and held 50 cycles -> trigger=1 only after edge 6, for one cycle. A 3-cycle pulse, or bouncing 1,0,1,0 -> no trigger. Release and re-press -> a second single pulse.
- Single capture (CLKS_PER_BIT=8): data_out 00->A5 -> fifo_count=1, then 0 after the pop. tx frame = start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 8 cycles, busy high for 80 cycles.
- Sequence: data_out steps 01,03,07,0F,1F,3F,7F,FF on consecutive cycles (FIFO_DEPTH=4) -> first value popped to TX, next four queued. Remaining values dropped -> overflow=1. Host receives 01,03,07,0F,1F in order, back-to-back, one IDLE cycle apart.
- Push/pop collision: FIFO full, data_out changes in the same cycle the FSM pops in IDLE -> push accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 and busy=0 immediately. After release, the FIFO is empty and no partial frame resumes.

Source files
------------

// File: rtl/io_bridge.sv
// io_bridge: debounced button trigger plus change-capture FIFO streamed out as 8N1 UART.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   btn_in     raw asynchronous pushbutton level
//   trigger    one-cycle pulse on a debounced press
//   data_out   CPU output bus, synchronous to clk
//   tx         UART serial out, idle high
//   busy       UART frame in progress
//   fifo_count entries queued
//   overflow   sticky flag: a changed value was dropped
module io_bridge #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLKS_PER_BIT    = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_in,
    output logic                          trigger,
    input  logic [7:0]                    data_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          s1_q, s2_q, btn_q, trig_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            btn_q  <= 1'b0;
            trig_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= btn_in;
            s2_q   <= s1_q;
            trig_q <= 1'b0;
            if (s2_q == btn_q)
                cnt_q <= '0;
            else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_q  <= s2_q;
                cnt_q  <= '0;
                // only the accepted 0->1 transition pulses; release is silent
                trig_q <= s2_q;
            end else
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign trigger = trig_q;

    logic [7:0]    last_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, push, pop, push_ok;
    state_t        state_q;

    always_comb begin
        push    = data_out != last_q;
        pop     = (state_q == IDLE) && (count_q != '0);
        // a pop in the same cycle frees a slot, so a full FIFO still accepts
        push_ok = push && ((count_q < CW'(FIFO_DEPTH)) || pop);
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q] <= data_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= 8'h00;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            last_q  <= data_out;
            count_q <= count_d;
            if (push_ok)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            if (push && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    assign fifo_count = count_q;
    assign overflow   = ovf_q;

    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q, baud_last;

    assign baud_last = baud_q == BW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (state_q != IDLE)
                baud_q <= baud_last ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    shift_q <= mem_q[rd_q];
                    state_q <= START;
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                START: if (baud_last) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= shift_q[0];
                end
                DATA: if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        shift_q <= shift_q >> 1;
                        // drive the next bit straight from the pre-shift value
                        tx_q    <= shift_q[1];
                    end
                end
                STOP: if (baud_last) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge.
module tb_io_bridge;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       trigger, tx, busy, overflow;
    logic [2:0] fifo_count;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_bridge #(.DEBOUNCE_CYCLES(4), .CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .trigger(trigger), .data_out(data_out),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn_in = 1'b0;
        data_out = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic rx_frame(output logic [7:0] b, output logic good, output int start);
        int n = 0;
        b = 'x;
        good = 1'b0;
        start = -1;
        while (tx !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (tx !== 1'b0) return;
        start = cyc;
        repeat (4) tick();
        good = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (8) tick();
            b[i] = tx;
        end
        repeat (8) tick();
        good = good && (tx === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_in = 1'b1;
        data_out = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({trigger, tx, busy, fifo_count, overflow} !== 7'b0100000) begin
                bad++;
                $display("FAIL reset_hold got=%b exp=%b", {trigger, tx, busy, fifo_count, overflow}, 7'b0100000);
            end
        end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (trigger !== (k == 6)) begin
                bad++;
                $display("FAIL reset_release_trigger edge=%0d got=%b exp=%b", k, trigger, (k == 6));
            end
            if (k == 1) begin
                total++;
                if (fifo_count !== 3'd1) begin
                    bad++;
                    $display("FAIL reset_release_count got=%0d exp=1", fifo_count);
                end
            end
        end
    endtask

    task automatic test_debounce();
        int n;
        do_reset();
        btn_in = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            total++;
            if (trigger !== (k == 6)) begin
                bad++;
                $display("FAIL press_trigger edge=%0d got=%b exp=%b", k, trigger, (k == 6));
            end
        end
        btn_in = 1'b0;
        n = 0;
        repeat (10) begin tick(); n += int'(trigger); end
        total++;
        if (n !== 0) begin bad++; $display("FAIL release_pulses got=%0d exp=0", n); end
        btn_in = 1'b1;
        repeat (3) tick();
        btn_in = 1'b0;
        n = 0;
        repeat (15) begin tick(); n += int'(trigger); end
        total++;
        if (n !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", n); end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0);
            tick();
            n += int'(trigger);
        end
        repeat (12) begin tick(); n += int'(trigger); end
        total++;
        if (n !== 0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", n); end
        btn_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (trigger !== (k == 6)) begin
                bad++;
                $display("FAIL repress_trigger edge=%0d got=%b exp=%b", k, trigger, (k == 6));
            end
        end
        btn_in = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_single_capture();
        logic [9:0] fr = {1'b1, 8'hA5, 1'b0};
        do_reset();
        data_out = 8'hA5;
        tick();
        total++;
        if (fifo_count !== 3'd1 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_push count=%0d tx=%b exp count=1 tx=1", fifo_count, tx);
        end
        tick();
        total++;
        if (fifo_count !== 3'd0 || tx !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_pop count=%0d tx=%b busy=%b exp 0 0 1", fifo_count, tx, busy);
        end
        for (int k = 3; k <= 81; k++) begin
            tick();
            total++;
            if (tx !== fr[(k - 2) / 8] || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_frame edge=%0d tx=%b busy=%b exp tx=%b busy=1", k, tx, busy, fr[(k - 2) / 8]);
            end
        end
        tick();
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_end busy=%b tx=%b exp busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] vals [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        logic [7:0] got [5];
        logic       good [5];
        int         st [5];
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    data_out = vals[i];
                    tick();
                end
                total++;
                if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
                    bad++;
                    $display("FAIL seq_fill count=%0d ovf=%b exp count=4 ovf=1", fifo_count, overflow);
                end
            end
            begin
                for (int j = 0; j < 5; j++) rx_frame(got[j], good[j], st[j]);
            end
        join
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got[i] !== vals[i] || good[i] !== 1'b1) begin
                bad++;
                $display("FAIL seq_frame%0d got=%h framing=%b exp=%h framing=1", i, got[i], good[i], vals[i]);
            end
            if (i > 0) begin
                total++;
                if (st[i] - st[i - 1] !== 81) begin
                    bad++;
                    $display("FAIL seq_gap%0d got=%0d exp=81", i, st[i] - st[i - 1]);
                end
            end
        end
        repeat (20) tick();
        total++;
        if (fifo_count !== 3'd0 || overflow !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL seq_drain count=%0d ovf=%b busy=%b tx=%b exp 0 1 0 1", fifo_count, overflow, busy, tx);
        end
    endtask

    task automatic test_collision();
        logic [7:0] got;
        logic       good;
        int         st;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            data_out = 8'(i);
            tick();
        end
        total++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL coll_full count=%0d ovf=%b exp count=4 ovf=0", fifo_count, overflow);
        end
        repeat (77) tick();
        total++;
        if (busy !== 1'b0 || fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL coll_idle busy=%b count=%0d exp busy=0 count=4", busy, fifo_count);
        end
        data_out = 8'h06;
        tick();
        total++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL coll_same_cycle count=%0d ovf=%b busy=%b exp 4 0 1", fifo_count, overflow, busy);
        end
        for (int i = 2; i <= 6; i++) begin
            rx_frame(got, good, st);
            total++;
            if (got !== 8'(i) || good !== 1'b1) begin
                bad++;
                $display("FAIL coll_frame got=%h framing=%b exp=%h framing=1", got, good, 8'(i));
            end
        end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL coll_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        data_out = 8'hA5;
        tick();
        tick();
        data_out = 8'h5A;
        tick();
        repeat (33) tick();
        total++;
        if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL mid_bit3 tx=%b busy=%b count=%0d exp 0 1 1", tx, busy, fifo_count);
        end
        rst = 1'b0;
        data_out = 8'h00;
        #1;
        total++;
        if ({tx, busy, fifo_count, overflow} !== 6'b100000) begin
            bad++;
            $display("FAIL mid_async got=%b exp=%b", {tx, busy, fifo_count, overflow}, 6'b100000);
        end
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            total++;
            if ({tx, busy, fifo_count} !== 5'b10000) begin
                bad++;
                $display("FAIL mid_after cycle=%0d got=%b exp=%b", k, {tx, busy, fifo_count}, 5'b10000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_single_capture();
        test_sequence();
        test_collision();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
